prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 8..1023.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rx  in  1  serial program stream, 8N1, LSB first, idle high; asynchronous to clk.
REQ-005 inst_address  out  7  instruction-memory write address for the CPU core.
REQ-006 inst_data  out  8  instruction-memory write data.
REQ-007 inst_we  out  1  single-cycle write strobe qualifying inst_address/inst_data.
REQ-008 cpu_rst_n  out  1  active-low hold of the downstream CPU; low while no verified program is loaded.
REQ-009 busy  out  1  high while a load frame is in progress (after sync byte, until checksum byte ends).
REQ-010 err  out  1  sticky error flag, set by a failed frame, cleared at the next accepted sync byte.

Function
REQ-011 rx passes through a 2-flop synchronizer reset to 1; all logic uses the synchronized value.
REQ-012 Receiver: synchronized falling edge in idle starts a bit timer; at CLKS_PER_BIT/2 the start bit is re-sampled; high -> false start, return to idle, no byte.
REQ-013 Data bits are sampled every CLKS_PER_BIT cycles after the start-bit mid-sample; the stop bit is sampled one bit period after bit 7.
REQ-014 Stop bit high -> byte_valid pulses one cycle with the assembled byte; stop bit low -> framing error.
REQ-015 Frame FSM states: SYNC, ADDR, LEN, DATA, CSUM; the state changes only on byte_valid or framing error.
REQ-016 SYNC: byte 0xA5 -> ADDR, err<=0, busy<=1, cpu_rst_n<=0; any other byte is ignored and the FSM stays in SYNC.
REQ-017 ADDR: byte[6:0] loads the write pointer; byte[7] is ignored; next state is LEN.
REQ-018 LEN: L=0 -> CSUM; 1<=L<=128 -> remaining count<=L, checksum<=0, next state DATA; L>128 -> err<=1, busy<=0, next state SYNC.
REQ-019 DATA: each byte drives inst_data<=byte, inst_address<=pointer, inst_we=1 for exactly the cycle after byte_valid; then pointer+1 mod 128 (127 wraps to 0), checksum+=byte mod 256, count-1; count reaching 0 -> CSUM.
REQ-020 inst_address and inst_data hold their last values between strobes; inst_we is never high two consecutive cycles.
REQ-021 CSUM: byte == checksum -> cpu_rst_n<=1 on the cycle after byte_valid; byte != checksum -> err<=1 and cpu_rst_n stays 0; both cases set busy<=0 and return to SYNC. With L=0 the expected checksum is 0x00.
REQ-022 A framing error in any state other than SYNC -> err<=1, busy<=0, cpu_rst_n stays 0, next state SYNC; a framing error in SYNC is ignored.
REQ-023 A new sync byte after a successful load re-asserts cpu_rst_n low, so the CPU is held during every reload.
REQ-024 Writes already issued by an aborted frame are not undone; cpu_rst_n staying low covers them.

Reset
REQ-025 While rst_n=0: FSM=SYNC, receiver idle, inst_we=0, inst_address=0, inst_data=0, cpu_rst_n=0, busy=0, err=0, pointer/count/checksum=0.
REQ-026 Reset asserted mid-byte or mid-frame aborts at once with no further inst_we; after rst_n deasserts, only the next 0xA5 starts a load.

Verification
REQ-027 CLKS_PER_BIT=16; bytes A5,10,03,11,22,33,66 -> writes (0x10,0x11),(0x11,0x22),(0x12,0x33), each a one-cycle inst_we; then cpu_rst_n=1, busy=0, err=0.
REQ-028 Bytes A5,7E,03,01,02,03,06 -> writes at 0x7E,0x7F,0x00 (wrap); cpu_rst_n=1.
REQ-029 Bytes A5,00,02,FF,02,00 (expected checksum 0x01) -> two writes, err=1, cpu_rst_n=0; a following good frame clears err and sets cpu_rst_n=1.
REQ-030 Bytes 00,5A,A5,20,81 -> no writes, err=1 after the LEN byte, FSM back in SYNC; 8-cycle low glitch on idle rx -> no byte, no state change.
REQ-031 A5,20,02,44, then a byte with stop bit 0 -> one write (0x20,0x44), err=1, cpu_rst_n=0; rst_n pulsed mid-byte -> all outputs at reset values, no inst_we.
REQ-032 Assertions checked throughout: inst_we never high 2 consecutive cycles; cpu_rst_n rises only on the cycle after a matching checksum byte.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: serial program loader for a small CPU core.
//
// The loader receives a program over an 8N1 serial line (LSB first, idle
// high) in frames of the form
//     0xA5, address, length, data[0..length-1], checksum
// and writes each data byte into the CPU's instruction memory at
// consecutive addresses, which wrap modulo 128. The checksum is the modulo-256
// sum of the data bytes. The CPU is held in reset until a frame's checksum
// matches, and it is held again as soon as a new sync byte starts a reload.
//
// Ports:
//   clk           clock; all state updates on its rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial program stream, asynchronous to clk
//   inst_address  instruction-memory write address (7 bits)
//   inst_data     instruction-memory write data (8 bits)
//   inst_we       one-cycle write strobe for inst_address/inst_data
//   cpu_rst_n     active-low CPU hold; high only after a verified load
//   busy          high from the sync byte until the frame ends
//   err           sticky error flag; cleared by the next sync byte
module prog_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [6:0] inst_address,
    output logic [7:0] inst_data,
    output logic       inst_we,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic       err
);

    localparam logic [9:0] HALF_BIT = 10'(CLKS_PER_BIT / 2);
    localparam logic [9:0] LAST_TICK = 10'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] MAX_LEN = 8'd128;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_ADDR, S_LEN, S_DATA, S_CSUM} frame_state_t;

    logic        rx_meta, rx_sync, rx_prev;

    rx_state_t   rx_state, rx_state_nxt;
    logic [9:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        byte_valid, byte_valid_nxt;
    logic        frame_err, frame_err_nxt;

    frame_state_t state, state_nxt;
    logic [6:0]  ptr, ptr_nxt;
    logic [7:0]  remain, remain_nxt;
    logic [7:0]  csum, csum_nxt;
    logic [6:0]  inst_address_nxt;
    logic [7:0]  inst_data_nxt;
    logic        inst_we_nxt, cpu_rst_n_nxt, busy_nxt, err_nxt;

    // Two-flop synchronizer plus one more stage for falling-edge detection.
    // All stages reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    // Byte receiver. The start bit is re-checked half a bit after the
    // synchronized falling edge; after that every sample lands one full bit
    // period later, i.e. near the middle of each data bit and of the stop bit.
    always_comb begin
        rx_state_nxt   = rx_state;
        bit_cnt_nxt    = bit_cnt + 10'd1;
        bit_idx_nxt    = bit_idx;
        shift_nxt      = shift;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                bit_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (!rx_sync && rx_prev) begin
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (bit_cnt == HALF_BIT) begin
                    bit_cnt_nxt  = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_cnt == LAST_TICK) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = {rx_sync, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (bit_cnt == LAST_TICK) begin
                    bit_cnt_nxt  = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SYNC;
            ptr          <= '0;
            remain       <= '0;
            csum         <= '0;
            inst_address <= '0;
            inst_data    <= '0;
            inst_we      <= 1'b0;
            cpu_rst_n    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            remain       <= remain_nxt;
            csum         <= csum_nxt;
            inst_address <= inst_address_nxt;
            inst_data    <= inst_data_nxt;
            inst_we      <= inst_we_nxt;
            cpu_rst_n    <= cpu_rst_n_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
        end
    end

    // Frame parser. It only moves on a received byte or a framing error.
    // Because byte_valid is a single-cycle pulse many cycles apart, the
    // registered write strobe can never be high on two consecutive cycles.
    always_comb begin
        state_nxt        = state;
        ptr_nxt          = ptr;
        remain_nxt       = remain;
        csum_nxt         = csum;
        inst_address_nxt = inst_address;
        inst_data_nxt    = inst_data;
        inst_we_nxt      = 1'b0;
        cpu_rst_n_nxt    = cpu_rst_n;
        busy_nxt         = busy;
        err_nxt          = err;
        if (frame_err && state != S_SYNC) begin
            err_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_SYNC;
        end else if (byte_valid) begin
            case (state)
                S_SYNC: begin
                    if (shift == SYNC_BYTE) begin
                        state_nxt     = S_ADDR;
                        err_nxt       = 1'b0;
                        busy_nxt      = 1'b1;
                        cpu_rst_n_nxt = 1'b0;
                    end
                end
                S_ADDR: begin
                    ptr_nxt   = shift[6:0];
                    state_nxt = S_LEN;
                end
                S_LEN: begin
                    // The checksum is cleared even for an empty frame so that
                    // a zero-length load expects a checksum byte of 0x00.
                    csum_nxt   = '0;
                    remain_nxt = shift;
                    if (shift == 8'd0) begin
                        state_nxt = S_CSUM;
                    end else if (shift <= MAX_LEN) begin
                        state_nxt = S_DATA;
                    end else begin
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = S_SYNC;
                    end
                end
                S_DATA: begin
                    inst_address_nxt = ptr;
                    inst_data_nxt    = shift;
                    inst_we_nxt      = 1'b1;
                    ptr_nxt          = ptr + 7'd1;
                    csum_nxt         = csum + shift;
                    remain_nxt       = remain - 8'd1;
                    if (remain == 8'd1) begin
                        state_nxt = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (shift == csum) begin
                        cpu_rst_n_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    busy_nxt  = 1'b0;
                    state_nxt = S_SYNC;
                end
                default: state_nxt = S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
//
// Bytes are sent over rx as 8N1 serial frames. A byte-stream model works out,
// from the frame format alone, which instruction-memory writes should appear
// and what cpu_rst_n, busy and err should read once each byte has been
// received. Directed frames cover the normal, wrap, checksum, length and
// framing-error cases, then randomized frames exercise the same rules.
module tb_prog_loader;

    localparam int CLKS = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [6:0] inst_address;
    logic [7:0] inst_data;
    logic       inst_we;
    logic       cpu_rst_n;
    logic       busy;
    logic       err;

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model state.
    bit          m_in_frame;
    logic [7:0]  m_frame[$];
    logic        m_err, m_busy, m_cpu;
    int          m_rises;
    logic [6:0]  m_last_addr;
    logic [7:0]  m_last_data;
    logic [14:0] exp_wr[$];

    // Observed activity collected by the monitor.
    logic [14:0] obs_wr[$];
    int          obs_rises = 0;
    logic        prev_we = 1'b0;
    logic        prev_cpu = 1'b0;

    prog_loader #(.CLKS_PER_BIT(CLKS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .inst_address (inst_address),
        .inst_data    (inst_data),
        .inst_we      (inst_we),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: record every write strobe and every rising edge of cpu_rst_n,
    // and flag back-to-back strobes or any strobe while reset is held.
    always @(negedge clk) begin
        if (inst_we) begin
            obs_wr.push_back({inst_address, inst_data});
            checkOutput("we_consecutive", int'(prev_we), 0);
            checkOutput("we_in_reset", int'(!rst_n), 0);
        end
        if (cpu_rst_n && !prev_cpu) begin
            obs_rises <= obs_rises + 1;
        end
        prev_we  <= inst_we;
        prev_cpu <= cpu_rst_n;
    end

    // Frame model, one received byte at a time.
    task automatic modelByte(input logic [7:0] b, input bit stop_ok);
        int n;
        int len;
        int base;
        int sum;
        logic [7:0] first;
        logic [7:0] lenb;
        if (!m_in_frame) begin
            if (stop_ok && b == 8'hA5) begin
                m_in_frame = 1'b1;
                m_frame.delete();
                m_err  = 1'b0;
                m_busy = 1'b1;
                m_cpu  = 1'b0;
            end
            return;
        end
        if (!stop_ok) begin
            m_in_frame = 1'b0;
            m_err  = 1'b1;
            m_busy = 1'b0;
            return;
        end
        m_frame.push_back(b);
        n = m_frame.size();
        if (n == 1) return;
        lenb = m_frame[1];
        len  = int'(lenb);
        if (n == 2) begin
            if (len > 128) begin
                m_in_frame = 1'b0;
                m_err  = 1'b1;
                m_busy = 1'b0;
            end
            return;
        end
        if (n <= len + 2) begin
            first = m_frame[0];
            base = int'(first) % 128;
            m_last_addr = 7'((base + n - 3) % 128);
            m_last_data = b;
            exp_wr.push_back({m_last_addr, m_last_data});
            return;
        end
        sum = 0;
        for (int i = 2; i < n - 1; i++) sum += int'(m_frame[i]);
        sum = sum % 256;
        if (int'(b) == sum) begin
            m_cpu = 1'b1;
            m_rises++;
        end else begin
            m_err = 1'b1;
        end
        m_busy = 1'b0;
        m_in_frame = 1'b0;
    endtask

    task automatic modelReset();
        m_in_frame  = 1'b0;
        m_frame.delete();
        m_err       = 1'b0;
        m_busy      = 1'b0;
        m_cpu       = 1'b0;
        m_last_addr = '0;
        m_last_data = '0;
    endtask

    task automatic checkState(input string where);
        logic [14:0] o;
        logic [14:0] e;
        checkOutput({where, ":cpu_rst_n"}, int'(cpu_rst_n), int'(m_cpu));
        checkOutput({where, ":busy"}, int'(busy), int'(m_busy));
        checkOutput({where, ":err"}, int'(err), int'(m_err));
        checkOutput({where, ":cpu_rises"}, obs_rises, m_rises);
        checkOutput({where, ":wr_count"}, obs_wr.size(), exp_wr.size());
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            checkOutput({where, ":wr_addr"}, int'(o[14:8]), int'(e[14:8]));
            checkOutput({where, ":wr_data"}, int'(o[7:0]), int'(e[7:0]));
        end
        obs_wr.delete();
        exp_wr.delete();
        checkOutput({where, ":hold_addr"}, int'(inst_address), int'(m_last_addr));
        checkOutput({where, ":hold_data"}, int'(inst_data), int'(m_last_data));
    endtask

    task automatic checkResetValues(input string where);
        checkOutput({where, ":inst_address"}, int'(inst_address), 0);
        checkOutput({where, ":inst_data"}, int'(inst_data), 0);
        checkOutput({where, ":inst_we"}, int'(inst_we), 0);
        checkOutput({where, ":cpu_rst_n"}, int'(cpu_rst_n), 0);
        checkOutput({where, ":busy"}, int'(busy), 0);
        checkOutput({where, ":err"}, int'(err), 0);
    endtask

    task automatic sendBit(input logic v);
        rx = v;
        repeat (CLKS) @(negedge clk);
    endtask

    // Send one byte (stop bit forced low when stop_ok is 0), idle a little,
    // then compare the DUT against the model.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int idle_bits);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stop_ok ? 1'b1 : 1'b0);
        for (int i = 0; i < idle_bits; i++) sendBit(1'b1);
        modelByte(b, stop_ok);
        checkState($sformatf("byte_%02h", b));
    endtask

    task automatic sendFrame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) applyStimulus(bytes[i], 1'b1, 1);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] sum;
        logic [7:0] len;
        logic [7:0] g;
        int kind;
        int bad_pos;

        rx    = 1'b1;
        rst_n = 1'b0;
        modelReset();
        m_rises = 0;
        repeat (4) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (2 * CLKS) @(negedge clk);

        $display("[TB] basic three-byte load");
        fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        sendFrame(fr);

        $display("[TB] address wrap 7F -> 00");
        fr = '{8'hA5, 8'h7E, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
        sendFrame(fr);

        $display("[TB] bad checksum, then recovery");
        fr = '{8'hA5, 8'h00, 8'h02, 8'hFF, 8'h02, 8'h00};
        sendFrame(fr);
        fr = '{8'hA5, 8'h05, 8'h01, 8'h09, 8'h09};
        sendFrame(fr);

        $display("[TB] junk before sync, oversize length");
        fr = '{8'h00, 8'h5A, 8'hA5, 8'h20, 8'h81};
        sendFrame(fr);

        $display("[TB] short low glitch on idle line");
        rx = 1'b0;
        repeat (CLKS / 2) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CLKS) @(negedge clk);
        checkState("glitch");

        $display("[TB] empty frame");
        fr = '{8'hA5, 8'h33, 8'h00, 8'h00};
        sendFrame(fr);

        $display("[TB] framing error mid-frame");
        fr = '{8'hA5, 8'h20, 8'h02, 8'h44};
        sendFrame(fr);
        applyStimulus(8'h55, 1'b0, 2);

        $display("[TB] reset pulsed mid-byte");
        fr = '{8'hA5, 8'h40, 8'h01};
        sendFrame(fr);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("mid_byte_reset");
        rx = 1'b1;
        modelReset();
        obs_wr.delete();
        exp_wr.delete();
        rst_n = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        checkState("after_reset");
        fr = '{8'h77, 8'hA5, 8'h12, 8'h02, 8'hF0, 8'h20, 8'h10};
        sendFrame(fr);

        $display("[TB] randomized frames");
        for (int f = 0; f < 16; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                applyStimulus(g, 1'($urandom_range(0, 1)), 1);
            end
            applyStimulus(8'hA5, 1'b1, $urandom_range(1, 2));
            applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1);
            if (kind == 1) begin
                applyStimulus(8'($urandom_range(129, 255)), 1'b1, 1);
                continue;
            end
            len = 8'($urandom_range(0, 8));
            applyStimulus(len, 1'b1, 1);
            sum = 8'h00;
            bad_pos = (kind == 3 && len != 8'd0) ? $urandom_range(0, int'(len) - 1) : -1;
            for (int i = 0; i < int'(len); i++) begin
                g = 8'($urandom_range(0, 255));
                if (i == bad_pos) begin
                    applyStimulus(g, 1'b0, 2);
                    break;
                end
                sum = sum + g;
                applyStimulus(g, 1'b1, $urandom_range(1, 2));
            end
            if (bad_pos >= 0) continue;
            if (kind == 2) sum = sum ^ 8'($urandom_range(1, 255));
            applyStimulus(sum, 1'b1, $urandom_range(1, 2));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
